// File: rtl/hcsr04_ranger_if.sv
// hcsr04_ranger_if: request, sensor and result signals shared between the ranger and its user
interface hcsr04_ranger_if #(parameter int DIST_W = 9);
  logic start;
  logic echo;
  logic trig;
  logic valid;
  logic timeout;
  logic busy;
  logic [DIST_W-1:0] distance_cm;
  modport master(output start, echo, input trig, distance_cm, valid, timeout, busy);
  modport slave(input start, echo, output trig, distance_cm, valid, timeout, busy);
endinterface

// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: HC-SR04 trigger/echo ranging with divider-free cm conversion; HCSR04_AUTO_TRIG_EN selects free-running triggers
module hcsr04_ranger #(
  parameter int TRIG_US = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US = 60000,
  parameter int CM_DIV = 58,
  parameter int DIST_W = 9
) (
  input logic clk_50MHz,
  input logic rst,
  input logic clk_1MHz,
  hcsr04_ranger_if.slave s
);
  localparam int TW = $clog2((TIMEOUT_US > TRIG_US ? TIMEOUT_US : TRIG_US) + 1);
  localparam int PW = $clog2(PERIOD_US + 1);
  localparam int SW = $clog2(CM_DIV);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;
  state_t state, state_n;
  logic [2:0] ck, ec;
  logic us_tick, rise, fall, tmo, go, abort, wrap;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [PW-1:0] per_cnt, per_n;
  logic [SW-1:0] sub, sub_n;
  logic [DIST_W-1:0] acc, acc_n, dist_n;
  logic trig_n, valid_n, to_n;
  assign rise = ec[1] & ~ec[2];
  assign fall = ~ec[1] & ec[2];
  assign tmo = us_tick && tick_cnt == TW'(TIMEOUT_US - 1);
  assign wrap = sub == SW'(CM_DIV - 1);
`ifdef HCSR04_AUTO_TRIG_EN
  assign go = us_tick;
`else
  assign go = s.start;
`endif
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state <= IDLE;
      ck <= '0;
      ec <= '0;
      us_tick <= 1'b0;
      tick_cnt <= '0;
      per_cnt <= '0;
      sub <= '0;
      acc <= '0;
      s.trig <= 1'b0;
      s.distance_cm <= '0;
      s.valid <= 1'b0;
      s.timeout <= 1'b0;
      s.busy <= 1'b0;
    end else begin
      ck <= {ck[1:0], clk_1MHz};
      ec <= {ec[1:0], s.echo};
      us_tick <= ck[1] & ~ck[2];
      state <= state_n;
      tick_cnt <= tick_n;
      per_cnt <= per_n;
      sub <= sub_n;
      acc <= acc_n;
      s.trig <= trig_n;
      s.distance_cm <= dist_n;
      s.valid <= valid_n;
      s.timeout <= to_n;
      s.busy <= state_n != IDLE;
    end
  end
  always_comb begin
    state_n = state;
    tick_n = tick_cnt;
    per_n = (us_tick && per_cnt != PW'(PERIOD_US)) ? per_cnt + 1'b1 : per_cnt;
    sub_n = sub;
    acc_n = acc;
    trig_n = s.trig;
    dist_n = s.distance_cm;
    valid_n = 1'b0;
    to_n = s.timeout;
    abort = 1'b0;
    case (state)
      IDLE: if (go) begin
        state_n = TRIG;
        trig_n = 1'b1;
        per_n = '0;
        tick_n = '0;
      end
      TRIG: if (us_tick) begin
        tick_n = tick_cnt == TW'(TRIG_US - 1) ? '0 : tick_cnt + 1'b1;
        trig_n = tick_cnt != TW'(TRIG_US - 1);
        state_n = trig_n ? TRIG : WAIT_ECHO;
      end
      WAIT_ECHO: if (rise) begin
        state_n = MEASURE;
        sub_n = '0;
        acc_n = '0;
        tick_n = '0;
      end else if (us_tick) begin
        tick_n = tick_cnt + 1'b1;
        abort = tmo;
      end
      MEASURE: if (fall) begin
        state_n = HOLDOFF;
        dist_n = acc;
        valid_n = 1'b1;
        to_n = 1'b0;
      end else if (us_tick) begin
        tick_n = tick_cnt + 1'b1;
        sub_n = wrap ? '0 : sub + 1'b1;
        acc_n = (wrap && acc != '1) ? acc + 1'b1 : acc;
        abort = tmo;
      end
      HOLDOFF: if (per_cnt == PW'(PERIOD_US) && !ec[1]) begin
`ifdef HCSR04_AUTO_TRIG_EN
        state_n = TRIG;
        trig_n = 1'b1;
        per_n = '0;
        tick_n = '0;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
    // Aborts report saturated distance with the sticky timeout flag
    if (abort) begin
      state_n = HOLDOFF;
      dist_n = '1;
      valid_n = 1'b1;
      to_n = 1'b1;
    end
  end
endmodule

// File: tb/tb_hcsr04_ranger.sv
// tb_hcsr04_ranger: directed checks of the ranger with a scaled-down timebase (1 tick = 4 clk cycles)
module tb_hcsr04_ranger;
  localparam int DW = 6;
  logic clk = 0;
  logic rst = 1;
  logic clk_1MHz = 0;
  logic [1:0] ph = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt = 0;
  int nrise = 0;
  int thigh = 0;
  int last_rise = 0;
  logic [DW-1:0] vdist = '0;
  logic vto = 0;
  logic trig_d = 0;
  hcsr04_ranger_if #(.DIST_W(DW)) bus();
  hcsr04_ranger #(.TRIG_US(10), .TIMEOUT_US(300), .PERIOD_US(600), .CM_DIV(4), .DIST_W(DW)) dut (
    .clk_50MHz(clk),
    .rst(rst),
    .clk_1MHz(clk_1MHz),
    .s(bus.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    ph = ph + 2'd1;
    clk_1MHz = ph < 2'd2;
  end
  always @(negedge clk) begin
    cyc++;
    if (bus.valid === 1'b1) begin
      vcnt++;
      vdist = bus.distance_cm;
      vto = bus.timeout;
    end
    if (bus.trig === 1'b1) thigh++;
    if (bus.trig === 1'b1 && !trig_d) begin
      nrise++;
      last_rise = cyc;
    end
    trig_d = bus.trig === 1'b1;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic align();
    do step(); while (ph != 2'd2);
    @(negedge clk);
  endtask
  task automatic pulse_start();
    align();
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
  endtask
  task automatic wait_trig_low();
    int n = 0;
    step();
    while (bus.trig && n < 200) begin
      step();
      n++;
    end
  endtask
  task automatic wait_valid(input int bound);
    int v0 = vcnt;
    int n = 0;
    while (vcnt == v0 && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (vcnt == v0) begin
      errors++;
      $display("FAIL valid_wait: no valid pulse within %0d cycles, required one", bound);
    end
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    step();
    while (bus.busy && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", bus.busy, bound);
    end
  endtask
  task automatic run(input int gap, input int width);
    pulse_start();
    wait_trig_low();
    repeat (4 * gap) @(negedge clk);
    align();
    bus.echo = 1;
    repeat (4 * width) @(negedge clk);
    bus.echo = 0;
  endtask
  task automatic test_reset();
    repeat (4) step();
    checks += 5;
    if (bus.trig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b required 0", bus.trig); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.valid); end
    if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b required 0", bus.timeout); end
    if (bus.distance_cm !== '0) begin errors++; $display("FAIL reset_dist: got %0d required 0", bus.distance_cm); end
    @(negedge clk);
    rst = 0;
    repeat (20) step();
  endtask
  task automatic test_basic();
    int t0 = thigh;
    int v0 = vcnt;
    run(50, 40);
    wait_valid(100);
    wait_idle(3000);
    checks += 4;
    if (thigh - t0 != 40) begin errors++; $display("FAIL basic_trig_len: got %0d cycles required 40", thigh - t0); end
    if (vcnt - v0 != 1) begin errors++; $display("FAIL basic_valid_count: got %0d required 1", vcnt - v0); end
    if (vdist !== 6'd10) begin errors++; $display("FAIL basic_dist: got %0d required 10", vdist); end
    if (vto !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b required 0", vto); end
  endtask
  task automatic test_widths();
    int w[3] = '{3, 4, 100};
    logic [DW-1:0] e[3] = '{6'd0, 6'd1, 6'd25};
    for (int i = 0; i < 3; i++) begin
      run(5, w[i]);
      wait_valid(100);
      checks += 2;
      if (vdist !== e[i]) begin errors++; $display("FAIL width_%0d_dist: got %0d required %0d", w[i], vdist, e[i]); end
      if (vto !== 1'b0) begin errors++; $display("FAIL width_%0d_timeout: got %b required 0", w[i], vto); end
      wait_idle(3000);
    end
  endtask
  task automatic test_saturate();
    run(5, 280);
    wait_valid(100);
    checks += 2;
    if (vdist !== 6'd63) begin errors++; $display("FAIL sat_dist: got %0d required 63", vdist); end
    if (vto !== 1'b0) begin errors++; $display("FAIL sat_timeout: got %b required 0", vto); end
    wait_idle(3000);
  endtask
  task automatic test_no_echo();
    pulse_start();
    wait_valid(2000);
    checks += 2;
    if (vdist !== 6'd63) begin errors++; $display("FAIL noecho_dist: got %0d required 63", vdist); end
    if (vto !== 1'b1) begin errors++; $display("FAIL noecho_timeout: got %b required 1", vto); end
    wait_idle(3000);
    run(5, 40);
    wait_valid(100);
    checks += 2;
    if (vdist !== 6'd10) begin errors++; $display("FAIL recover_dist: got %0d required 10", vdist); end
    if (vto !== 1'b0) begin errors++; $display("FAIL recover_timeout: got %b required 0", vto); end
    wait_idle(3000);
  endtask
  task automatic test_echo_stuck();
    int v0 = vcnt;
    pulse_start();
    wait_trig_low();
    align();
    bus.echo = 1;
    wait_valid(1500);
    checks += 2;
    if (vdist !== 6'd63) begin errors++; $display("FAIL stuck_dist: got %0d required 63", vdist); end
    if (vto !== 1'b1) begin errors++; $display("FAIL stuck_timeout: got %b required 1", vto); end
    repeat (2400) step();
    checks += 2;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL stuck_holdoff: busy=%b required 1", bus.busy); end
    if (vcnt - v0 != 1) begin errors++; $display("FAIL stuck_valid_count: got %0d required 1", vcnt - v0); end
    @(negedge clk);
    bus.echo = 0;
    wait_idle(20);
  endtask
  task automatic test_start_ignored();
    int r0 = nrise;
    int v0 = vcnt;
    int prev;
    pulse_start();
    repeat (8) step();
    pulse_start();
    wait_trig_low();
    repeat (20) @(negedge clk);
    align();
    bus.echo = 1;
    repeat (40) @(negedge clk);
    pulse_start();
    repeat (100) @(negedge clk);
    bus.echo = 0;
    wait_valid(100);
    pulse_start();
    wait_idle(3000);
    repeat (200) step();
    checks += 3;
    if (nrise - r0 != 1) begin errors++; $display("FAIL ignore_rises: got %0d required 1", nrise - r0); end
    if (vcnt - v0 != 1) begin errors++; $display("FAIL ignore_valid_count: got %0d required 1", vcnt - v0); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: busy=%b required 0", bus.busy); end
    prev = last_rise;
    pulse_start();
    repeat (5) step();
    checks += 2;
    if (nrise - r0 != 2) begin errors++; $display("FAIL restart_rises: got %0d required 2", nrise - r0); end
    if (last_rise - prev < 2400) begin errors++; $display("FAIL restart_period: got %0d cycles required >= 2400", last_rise - prev); end
    wait_idle(3000);
  endtask
  task automatic test_reset_mid();
    int v0 = vcnt;
    pulse_start();
    wait_trig_low();
    align();
    bus.echo = 1;
    repeat (80) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks += 4;
    if (bus.trig !== 1'b0) begin errors++; $display("FAIL midrst_trig: got %b required 0", bus.trig); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", bus.busy); end
    if (bus.distance_cm !== '0) begin errors++; $display("FAIL midrst_dist: got %0d required 0", bus.distance_cm); end
    if (bus.timeout !== 1'b0) begin errors++; $display("FAIL midrst_timeout: got %b required 0", bus.timeout); end
    rst = 0;
    repeat (20) @(negedge clk);
    bus.echo = 0;
    repeat (40) step();
    checks++;
    if (vcnt != v0) begin errors++; $display("FAIL midrst_valid: got %0d pulses required 0", vcnt - v0); end
    run(5, 40);
    wait_valid(100);
    checks += 2;
    if (vdist !== 6'd10) begin errors++; $display("FAIL postrst_dist: got %0d required 10", vdist); end
    if (vto !== 1'b0) begin errors++; $display("FAIL postrst_timeout: got %b required 0", vto); end
    wait_idle(3000);
  endtask
  initial begin
    bus.start = 0;
    bus.echo = 0;
    test_reset();
    test_basic();
    test_widths();
    test_saturate();
    test_no_echo();
    test_echo_stuck();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
